ahb_bus_arbiter: RTL

Two-master AHB-Lite arbiter that sits upstream of the DMA controller's master port and the CPU master. It drives the DMA controller's `Bus_Grant`, multiplexes both masters' address/control/write-data onto the shared slave bus, and returns read data and ready to both masters. Bus ownership changes only on burst boundaries, so the controller's multi-beat transfers are never split.

---
 rtl/ahb_bus_arbiter_if.sv | 50 +++++
 rtl/ahb_bus_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter_if.sv
// Bus bundle for the two-master AHB-Lite arbiter: CPU master set, DMA
// controller master set, and the shared slave-side signals.
// "slave" is the arbiter's view; "master" is the view of whatever drives
// the requests and the slave responses (masters plus slave model).
interface ahb_bus_arbiter_if #(
  parameter int BEAT_W = 4
);
  // CPU master
  logic              CpuReq;
  logic [31:0]       CpuAddr;
  logic [1:0]        CpuTrans;
  logic              CpuWrite;
  logic [31:0]       CpuWData;
  logic [BEAT_W-1:0] CpuBurst_Size;
  logic              CpuGrant;
  logic [31:0]       CpuRData;
  // DMA controller master
  logic              Bus_Req;
  logic [31:0]       MAddress;
  logic [1:0]        MTrans;
  logic              MWrite;
  logic [31:0]       MWData;
  logic [BEAT_W-1:0] MBurst_Size;
  logic              Bus_Grant;
  logic [31:0]       MRData;
  // Shared slave bus
  logic              HReady;
  logic [31:0]       HRData;
  logic [31:0]       HAddr;
  logic [1:0]        HTrans;
  logic              HWrite;
  logic [31:0]       HWData;
  logic              HMaster;

  modport slave (
    input  CpuReq, CpuAddr, CpuTrans, CpuWrite, CpuWData, CpuBurst_Size,
    input  Bus_Req, MAddress, MTrans, MWrite, MWData, MBurst_Size,
    input  HReady, HRData,
    output CpuGrant, Bus_Grant, HAddr, HTrans, HWrite, HWData, HMaster,
    output MRData, CpuRData
  );

  modport master (
    output CpuReq, CpuAddr, CpuTrans, CpuWrite, CpuWData, CpuBurst_Size,
    output Bus_Req, MAddress, MTrans, MWrite, MWData, MBurst_Size,
    output HReady, HRData,
    input  CpuGrant, Bus_Grant, HAddr, HTrans, HWrite, HWData, HMaster,
    input  MRData, CpuRData
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Two-master (CPU / DMA) AHB-Lite arbiter. Ownership of the address phase
// only moves on burst boundaries; a beat counter loaded on NONSEQ holds the
// bus locked until the last SEQ beat of the burst has been accepted.
// Build option: ARB_ROUND_ROBIN_EN -- when defined, contention is resolved
// in favour of the master that did not own the bus last; otherwise DMA
// always beats CPU.
module ahb_bus_arbiter #(
  parameter bit DEFAULT_MASTER = 1'b0,  // 0 = CPU parked, 1 = DMA parked
  parameter int BEAT_W         = 4
) (
  input logic             clk,
  input logic             rst,
  ahb_bus_arbiter_if.slave bus
);

  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  // Grant vectors: bit 0 = CPU, bit 1 = DMA
  localparam logic [1:0] GNT_CPU   = 2'b01;
  localparam logic [1:0] GNT_DMA   = 2'b10;
  localparam logic [1:0] GNT_DEF   = DEFAULT_MASTER ? GNT_DMA : GNT_CPU;

  typedef enum logic [1:0] {
    PARK   = 2'd0,
    OWN    = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        dgnt_q, dgnt_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;

  logic [1:0]        own_trans;
  logic [BEAT_W-1:0] own_size;
  logic [1:0]        pick;
  logic              any_req;

  // Address-phase owner's view; the non-owner's signals never reach the bus
  assign own_trans = gnt_q[1] ? bus.MTrans      : bus.CpuTrans;
  assign own_size  = gnt_q[1] ? bus.MBurst_Size : bus.CpuBurst_Size;
  assign any_req   = bus.Bus_Req | bus.CpuReq;

  // Shared bus mux: address phase by gnt, write data by data-phase owner
  assign bus.HAddr     = gnt_q[1]  ? bus.MAddress : bus.CpuAddr;
  assign bus.HTrans    = own_trans;
  assign bus.HWrite    = gnt_q[1]  ? bus.MWrite   : bus.CpuWrite;
  assign bus.HWData    = dgnt_q[1] ? bus.MWData   : bus.CpuWData;
  assign bus.HMaster   = gnt_q[1];
  assign bus.CpuGrant  = gnt_q[0];
  assign bus.Bus_Grant = gnt_q[1];
  assign bus.MRData    = bus.HRData;
  assign bus.CpuRData  = bus.HRData;

  // Winner of an arbitration round, used only when the bus is free
  always_comb begin
    pick = GNT_DEF;
`ifdef ARB_ROUND_ROBIN_EN
    if (bus.Bus_Req && bus.CpuReq)
      pick = gnt_q[1] ? GNT_CPU : GNT_DMA;   // current owner is "last owner"
    else if (bus.Bus_Req)
      pick = GNT_DMA;
    else if (bus.CpuReq)
      pick = GNT_CPU;
`else
    if (bus.Bus_Req)
      pick = GNT_DMA;
    else if (bus.CpuReq)
      pick = GNT_CPU;
`endif
  end

  // Next-state: beat bookkeeping, lock, and re-arbitration on free bus.
  // The counter holds the beats still owed after the accepted one, so the
  // bus is locked exactly while it is non-zero; when the last beat of a
  // burst is accepted it reaches zero and arbitration runs that same edge.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    dgnt_d  = dgnt_q;
    cnt_d   = cnt_q;
    if (bus.HReady) begin
      dgnt_d = gnt_q;
      if (own_trans == TR_NONSEQ)
        cnt_d = (own_size > BEAT_W'(1)) ? own_size - BEAT_W'(1) : '0;
      else if (own_trans == TR_SEQ && cnt_q != '0)
        cnt_d = cnt_q - BEAT_W'(1);
      if (cnt_d != '0) begin
        state_d = LOCKED;
      end else begin
        gnt_d   = pick;
        state_d = any_req ? OWN : PARK;
      end
    end
  end

  // Arbiter state; HReady low leaves everything frozen via the holds above
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PARK;
      gnt_q   <= GNT_DEF;
      dgnt_q  <= GNT_DEF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      dgnt_q  <= dgnt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
